// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only identity, plus a 4-bit predicate.
// Operands are latched in REQUEST; ALU/LSU/immediate results commit in UPDATE under the predicate guard.
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic [3:0]           decoded_rd_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic                 decoded_pred_write_enable,
  input  logic [1:0]           decoded_pd_address,
  input  logic                 decoded_always_execute,
  input  logic                 decoded_predicate_on,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic [3:0]           predicate
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [3:0] LAST_GPR     = 4'd12;

  logic [DATA_BITS-1:0] gpr [0:12];
  logic [DATA_BITS-1:0] r13;
  logic [DATA_BITS-1:0] rs_val;
  logic [DATA_BITS-1:0] rt_val;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_valid;
  logic                 commit;
  logic                 do_update;
  logic                 data_we;
  logic                 pred_we;

  always_comb begin
    rs_val = '0;
    case (decoded_rs_address)
      4'd13:   rs_val = r13;
      4'd14:   rs_val = DATA_BITS'(THREADS_PER_BLOCK);
      4'd15:   rs_val = DATA_BITS'(THREAD_ID);
      default: rs_val = gpr[decoded_rs_address];
    endcase
  end

  always_comb begin
    rt_val = '0;
    case (decoded_rt_address)
      4'd13:   rt_val = r13;
      4'd14:   rt_val = DATA_BITS'(THREADS_PER_BLOCK);
      4'd15:   rt_val = DATA_BITS'(THREAD_ID);
      default: rt_val = gpr[decoded_rt_address];
    endcase
  end

  // Same gate as the ALU's execute check, so a suppressed instruction never writes back.
  assign commit = decoded_always_execute || !decoded_predicate_on || (predicate != 4'b0);

  always_comb begin
    wr_data      = '0;
    wr_src_valid = 1'b1;
    case (decoded_reg_input_mux)
      2'b00:   wr_data = alu_out;
      2'b01:   wr_data = lsu_out;
      2'b10:   wr_data = decoded_immediate;
      default: wr_src_valid = 1'b0;
    endcase
  end

  assign do_update = (core_state == CORE_UPDATE) && commit;
  assign data_we   = do_update && decoded_reg_write_enable && wr_src_valid &&
                     (decoded_rd_address <= LAST_GPR);
  assign pred_we   = do_update && decoded_pred_write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) gpr[i] <= '0;
      r13       <= DATA_BITS'(block_id);
      rs        <= '0;
      rt        <= '0;
      predicate <= 4'b0;
    end else if (enable) begin
      r13 <= DATA_BITS'(block_id);
      if (core_state == CORE_REQUEST) begin
        rs <= rs_val;
        rt <= rt_val;
      end
      if (data_we) gpr[decoded_rd_address] <= wr_data;
      if (pred_we) predicate[decoded_pd_address] <= alu_out[0];
    end
  end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: a table of one-cycle vectors with hand-computed
// rs/rt/predicate values after each edge, plus a hand-written operand-hold sequence.
module tb_thread_regfile;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_REQ  = 3'b011;
  localparam logic [2:0] ST_WAIT = 3'b100;
  localparam logic [2:0] ST_EXEC = 3'b101;
  localparam logic [2:0] ST_UPD  = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rs_addr, rt_addr, rd_addr;
  logic       reg_we;
  logic [1:0] reg_mux;
  logic [7:0] imm;
  logic       pred_we;
  logic [1:0] pd_addr;
  logic       always_exec;
  logic       pred_on;
  logic [7:0] alu_out, lsu_out;
  logic [7:0] rs, rt;
  logic [3:0] predicate;

  int n_vec  = 0;
  int n_miss = 0;

  thread_regfile #(.THREADS_PER_BLOCK(4), .THREAD_ID(9), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state),
    .decoded_rs_address(rs_addr), .decoded_rt_address(rt_addr),
    .decoded_rd_address(rd_addr), .decoded_reg_write_enable(reg_we),
    .decoded_reg_input_mux(reg_mux), .decoded_immediate(imm),
    .decoded_pred_write_enable(pred_we), .decoded_pd_address(pd_addr),
    .decoded_always_execute(always_exec), .decoded_predicate_on(pred_on),
    .alu_out(alu_out), .lsu_out(lsu_out),
    .rs(rs), .rt(rt), .predicate(predicate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rs_addr, rt_addr, rd_addr;
    logic       reg_we;
    logic [1:0] reg_mux;
    logic [7:0] imm;
    logic       pred_we;
    logic [1:0] pd_addr;
    logic       always_exec;
    logic       pred_on;
    logic [7:0] alu_out, lsu_out;
    logic [7:0] exp_rs, exp_rt;
    logic [3:0] exp_pred;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v_base(input logic [7:0] ers, input logic [7:0] ert,
                                  input logic [3:0] ep);
    vec_t v;
    v.reset = 1'b0; v.enable = 1'b1; v.block_id = 8'h05; v.core_state = ST_IDLE;
    v.rs_addr = 4'd0; v.rt_addr = 4'd0; v.rd_addr = 4'd0;
    v.reg_we = 1'b0; v.reg_mux = 2'b00; v.imm = 8'h00;
    v.pred_we = 1'b0; v.pd_addr = 2'd0; v.always_exec = 1'b1; v.pred_on = 1'b0;
    v.alu_out = 8'h00; v.lsu_out = 8'h00;
    v.exp_rs = ers; v.exp_rt = ert; v.exp_pred = ep;
    return v;
  endfunction

  function automatic vec_t v_req(input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] ers, input logic [7:0] ert,
                                 input logic [3:0] ep);
    vec_t v = v_base(ers, ert, ep);
    v.core_state = ST_REQ; v.rs_addr = a; v.rt_addr = b;
    return v;
  endfunction

  function automatic vec_t v_upd(input logic [3:0] rd, input logic we, input logic [1:0] mux,
                                 input logic [7:0] imm_v, input logic [7:0] alu_v,
                                 input logic [7:0] lsu_v,
                                 input logic [7:0] ers, input logic [7:0] ert,
                                 input logic [3:0] ep);
    vec_t v = v_base(ers, ert, ep);
    v.core_state = ST_UPD; v.rd_addr = rd; v.reg_we = we; v.reg_mux = mux;
    v.imm = imm_v; v.alu_out = alu_v; v.lsu_out = lsu_v;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.reset; enable = v.enable; block_id = v.block_id; core_state = v.core_state;
    rs_addr = v.rs_addr; rt_addr = v.rt_addr; rd_addr = v.rd_addr;
    reg_we = v.reg_we; reg_mux = v.reg_mux; imm = v.imm;
    pred_we = v.pred_we; pd_addr = v.pd_addr;
    always_exec = v.always_exec; pred_on = v.pred_on;
    alu_out = v.alu_out; lsu_out = v.lsu_out;
  endtask

  task automatic check(input string name, input logic [7:0] ers, input logic [7:0] ert,
                       input logic [3:0] ep);
    n_vec++;
    if (rs !== ers) begin
      n_miss++;
      $display("FAIL %s rs: got %h expected %h", name, rs, ers);
    end
    if (rt !== ert) begin
      n_miss++;
      $display("FAIL %s rt: got %h expected %h", name, rt, ert);
    end
    if (predicate !== ep) begin
      n_miss++;
      $display("FAIL %s predicate: got %b expected %b", name, predicate, ep);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.exp_rs, v.exp_rt, v.exp_pred);
  endtask

  initial begin
    vec_t v;

    // Reset, then identity registers (R13=block_id, R14=4, R15=9).
    v = v_base(8'h00, 8'h00, 4'b0000); v.reset = 1'b1;                      vecs.push_back(v);
    vecs.push_back(v_req(4'd13, 4'd14, 8'h05, 8'h04, 4'b0000));
    // Immediate write to R3.
    vecs.push_back(v_upd(4'd3, 1'b1, 2'b10, 8'h2A, 8'h00, 8'h00, 8'h05, 8'h04, 4'b0000));
    vecs.push_back(v_req(4'd3, 4'd15, 8'h2A, 8'h09, 4'b0000));
    // Writes to R15 and R13 are dropped.
    vecs.push_back(v_upd(4'd15, 1'b1, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h2A, 8'h09, 4'b0000));
    vecs.push_back(v_upd(4'd13, 1'b1, 2'b10, 8'hEE, 8'h00, 8'h00, 8'h2A, 8'h09, 4'b0000));
    vecs.push_back(v_req(4'd15, 4'd13, 8'h09, 8'h05, 4'b0000));
    // Predicate bit 2 set, then bit 0 set together with an ALU write to R5.
    v = v_upd(4'd0, 1'b0, 2'b00, 8'h00, 8'h01, 8'h00, 8'h09, 8'h05, 4'b0100);
    v.pred_we = 1'b1; v.pd_addr = 2'd2;                                     vecs.push_back(v);
    v = v_upd(4'd5, 1'b1, 2'b00, 8'h00, 8'h03, 8'h00, 8'h09, 8'h05, 4'b0101);
    v.pred_we = 1'b1; v.pd_addr = 2'd0;                                     vecs.push_back(v);
    vecs.push_back(v_req(4'd5, 4'd3, 8'h03, 8'h2A, 4'b0101));
    // Clear bit 2 only.
    v = v_upd(4'd0, 1'b0, 2'b00, 8'h00, 8'hFE, 8'h00, 8'h03, 8'h2A, 4'b0001);
    v.pred_we = 1'b1; v.pd_addr = 2'd2;                                     vecs.push_back(v);
    // Predicated instruction with nonzero predicate commits an LSU write to R6.
    v = v_upd(4'd6, 1'b1, 2'b01, 8'h00, 8'h00, 8'h77, 8'h03, 8'h2A, 4'b0001);
    v.always_exec = 1'b0; v.pred_on = 1'b1;                                 vecs.push_back(v);
    vecs.push_back(v_req(4'd6, 4'd0, 8'h77, 8'h00, 4'b0001));
    // Reset clears everything; predicated instruction with zero predicate is suppressed.
    v = v_base(8'h00, 8'h00, 4'b0000); v.reset = 1'b1;                      vecs.push_back(v);
    v = v_upd(4'd1, 1'b1, 2'b01, 8'h00, 8'h01, 8'h77, 8'h00, 8'h00, 4'b0000);
    v.always_exec = 1'b0; v.pred_on = 1'b1; v.pred_we = 1'b1; v.pd_addr = 2'd3;
    vecs.push_back(v);
    vecs.push_back(v_req(4'd1, 4'd14, 8'h00, 8'h04, 4'b0000));
    // enable low blocks the write to R2; enable high performs it.
    v = v_upd(4'd2, 1'b1, 2'b00, 8'h00, 8'h99, 8'h00, 8'h00, 8'h04, 4'b0000);
    v.enable = 1'b0;                                                        vecs.push_back(v);
    vecs.push_back(v_req(4'd2, 4'd13, 8'h00, 8'h05, 4'b0000));
    vecs.push_back(v_upd(4'd2, 1'b1, 2'b00, 8'h00, 8'h99, 8'h00, 8'h00, 8'h05, 4'b0000));
    vecs.push_back(v_req(4'd2, 4'd1, 8'h99, 8'h00, 4'b0000));
    // Reserved mux code does not write.
    vecs.push_back(v_upd(4'd2, 1'b1, 2'b11, 8'h55, 8'h55, 8'h55, 8'h99, 8'h00, 4'b0000));
    vecs.push_back(v_req(4'd0, 4'd2, 8'h00, 8'h99, 4'b0000));
    // Unused core_state does not write.
    v = v_upd(4'd7, 1'b1, 2'b10, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h99, 4'b0000);
    v.core_state = ST_WAIT;                                                 vecs.push_back(v);
    vecs.push_back(v_req(4'd7, 4'd15, 8'h00, 8'h09, 4'b0000));
    // Reset concurrent with an UPDATE write and predicate write.
    vecs.push_back(v_req(4'd13, 4'd15, 8'h05, 8'h09, 4'b0000));
    v = v_upd(4'd4, 1'b1, 2'b10, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0000);
    v.reset = 1'b1; v.pred_we = 1'b1; v.pd_addr = 2'd1;                     vecs.push_back(v);
    vecs.push_back(v_req(4'd4, 4'd15, 8'h00, 8'h09, 4'b0000));
    // REQUEST with enable low holds the operands.
    v = v_req(4'd13, 4'd14, 8'h00, 8'h09, 4'b0000); v.enable = 1'b0;        vecs.push_back(v);
    // R13 follows a new block_id.
    v = v_base(8'h00, 8'h09, 4'b0000); v.block_id = 8'h21;                  vecs.push_back(v);
    v = v_req(4'd13, 4'd4, 8'h21, 8'h00, 4'b0000); v.block_id = 8'h21;      vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Operand hold across WAIT/EXECUTE/UPDATE while read addresses change.
    v = v_upd(4'd8, 1'b1, 2'b10, 8'hA5, 8'h00, 8'h00, 8'h21, 8'h00, 4'b0000);
    v.block_id = 8'h21;
    step(v, "seq_wr_r8");
    v = v_req(4'd8, 4'd14, 8'hA5, 8'h04, 4'b0000); v.block_id = 8'h21;
    step(v, "seq_req_r8");
    v = v_base(8'hA5, 8'h04, 4'b0000); v.core_state = ST_WAIT; v.rs_addr = 4'd13;
    v.rt_addr = 4'd15; v.block_id = 8'h21;
    step(v, "seq_wait_hold");
    v.core_state = ST_EXEC;
    step(v, "seq_exec_hold");
    v = v_upd(4'd8, 1'b1, 2'b00, 8'h00, 8'h3E, 8'h00, 8'hA5, 8'h04, 4'b0000);
    v.block_id = 8'h21; v.rs_addr = 4'd13;
    step(v, "seq_upd_hold");
    v = v_req(4'd8, 4'd13, 8'h3E, 8'h21, 4'b0000); v.block_id = 8'h21;
    step(v, "seq_req_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file that feeds the thread's ALU and LSU operands and accepts their results at writeback. There is one instance per thread slot in each core, alongside that thread's ALU. It holds 13 general registers, 3 read-only identity registers and a 4-bit predicate register. Operands are captured in the REQUEST core state; results are committed in the UPDATE core state.

## Interface
Parameters:
- THREADS_PER_BLOCK, 4: value returned by R14 (blockDim).
- THREAD_ID, 0: value returned by R15 (threadIdx).
- DATA_BITS, 8: register width.

Ports (all synchronous to clk):
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  thread slot active; low freezes all state.
- block_id  in  8  current block index, mirrored into R13.
- core_state  in  3  core FSM state: REQUEST=3'b011, UPDATE=3'b110; all other codes are no-op for this block.
- decoded_rs_address  in  4  source register A.
- decoded_rt_address  in  4  source register B.
- decoded_rd_address  in  4  destination register.
- decoded_reg_write_enable  in  1  commit a data result in UPDATE.
- decoded_reg_input_mux  in  2  writeback source: 00 ALU, 01 LSU, 10 immediate, 11 reserved.
- decoded_immediate  in  8  constant for a 10 writeback.
- decoded_pred_write_enable  in  1  commit a comparison bit to the predicate register.
- decoded_pd_address  in  2  predicate bit index.
- decoded_always_execute  in  1  bypass the predicate guard.
- decoded_predicate_on  in  1  instruction is predicated.
- alu_out  in  8  ALU result; bit 0 is the compare result.
- lsu_out  in  8  load data.
- rs  out  8  operand A, registered.
- rt  out  8  operand B, registered.
- predicate  out  4  predicate register, registered.

## Operation
- Register map:
  - R0–R12 are read/write.
  - R13 = block_id, R14 = THREADS_PER_BLOCK, R15 = THREAD_ID.
  - Writes to R13–R15 are silently dropped.
- R13 tracks block_id: it is reloaded every enabled cycle, including during reset.
- Read: when enable and core_state==REQUEST, latch rs <= R[decoded_rs_address] and rt <= R[decoded_rt_address]. Otherwise rs and rt hold.
- Guard: commit = decoded_always_execute || !decoded_predicate_on || (predicate != 4'b0). This matches the ALU's execute gate, so a suppressed instruction never writes back.
- Data write: when enable, core_state==UPDATE, commit, decoded_reg_write_enable and rd ≤ 12, write R[rd] from the source selected by the mux:
  - 00 → alu_out
  - 01 → lsu_out
  - 10 → decoded_immediate
  - 11 → no write
- Predicate write: under the same enable/UPDATE/commit condition with decoded_pred_write_enable, write predicate[decoded_pd_address] <= alu_out[0]. The other predicate bits are unchanged.
- A data write and a predicate write in the same UPDATE cycle both take effect.
- The block does no arithmetic. Values are stored and returned unmodified, at full 8 bits.

## Timing
- Reset (synchronous, wins over every other input):
  - R0–R12 = 0, R13 = block_id.
  - rs = rt = 0, predicate = 4'b0.
- Read latency: rs and rt are valid the cycle after the REQUEST edge and stay stable through WAIT, EXECUTE and UPDATE.
- Write latency: the new value is visible in the register array the cycle after the UPDATE edge. It reaches rs/rt at the next REQUEST.
- predicate reflects a predicate write one cycle after the UPDATE edge. It feeds the ALU guard of the next instruction.
- Read and write occur in different core states, so there is no read/write collision and no bypass path is required.
- enable low: no register, operand or predicate change, even in REQUEST or UPDATE. R13 is also held.
- Reset mid-instruction (any core_state): all state returns to reset values on that edge, and a pending UPDATE is discarded.
- Unused core_state codes (000, 001, 010, 100, 101, 111): no state change except the R13 refresh.

## Test plan
- Reset with block_id=8'h05 → rs=0, rt=0, predicate=0. A REQUEST with rs_addr=13, rt_addr=14 then gives rs=8'h05, rt=8'h04.
- UPDATE with mux=10, imm=8'h2A, rd=3, we=1, always_execute=1, followed by REQUEST with rs_addr=3 → rs=8'h2A.
- UPDATE with mux=00, alu_out=8'hFF, rd=15, we=1 → R15 unchanged. A REQUEST with rt_addr=15 returns THREAD_ID.
- UPDATE with pred_we=1, pd=2, alu_out=8'h01 → predicate=4'b0100. Then UPDATE with predicate_on=1, always_execute=0, predicate=4'b0000 (after reset), rd=1, mux=01, lsu_out=8'h77 → R1 stays 0.
- UPDATE with enable=0, mux=00, alu_out=8'h99, rd=2 → R2 unchanged. Repeating with enable=1 → R2=8'h99.
- Same-cycle reset and UPDATE write (rd=4, imm=8'h10) → R4=0 and predicate=0 afterwards.
